// File: rtl/tdm_pkg.sv
// Purpose: shared types, defaults and slot-index helper for the TDM slot scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tdm_pkg;

  localparam int unsigned TDM_DEF_CHANNEL_NUM = 8;
  localparam int unsigned TDM_DEF_SLOT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } tdm_state_e;

  // Slot that follows 'cur' in a frame of 'num' slots, wrapping to slot 0.
  function automatic int unsigned tdm_next_slot(input int unsigned cur,
                                                input int unsigned num);
    return (cur >= num - 1) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/tdm_tx_hold.sv
// Purpose: one-entry per-channel TX holding register with valid/ready load and pop.
// Latency: a loaded word is visible on out_dat_o the cycle after the handshake.
// Backpressure: in_rdy_o is low while the entry is full or loading is disabled.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   flush_i       drop any held word (dominates load and pop)
//   accept_en_i   loading allowed (scheduler not idle)
//   in_vld_i/in_dat_i/in_rdy_o  producer handshake
//   pop_i         consume the held word (slot served)
//   out_vld_o/out_dat_o         held word and its valid flag
module tdm_tx_hold #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             accept_en_i,
  input  logic             in_vld_i,
  input  logic [WIDTH-1:0] in_dat_i,
  output logic             in_rdy_o,
  input  logic             pop_i,
  output logic             out_vld_o,
  output logic [WIDTH-1:0] out_dat_o
);

  logic             vld_q, vld_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic             load;

  assign in_rdy_o  = accept_en_i & ~vld_q;
  assign load      = in_vld_i & in_rdy_o;
  assign out_vld_o = vld_q;
  assign out_dat_o = dat_q;

  // A pop on an empty entry in the same cycle as a load leaves the new word
  // stored: load is applied after pop.
  always_comb begin
    vld_d = vld_q;
    dat_d = dat_q;
    if (flush_i) begin
      vld_d = 1'b0;
    end else begin
      if (pop_i) begin
        vld_d = 1'b0;
      end
      if (load) begin
        vld_d = 1'b1;
        dat_d = in_dat_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

endmodule

// File: rtl/tdm_slot_scheduler.sv
// Purpose: shares one TDM serializer PCM port among CHANNEL_NUM channel streams.
// Latency: pcm_tx_* and ch_rx_* pulse one cycle after the slot tick / rx valid.
// Backpressure: per-channel TX via one-entry holds (ch_tx_ready); RX has none.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   enable, slot_mask, clr_status  control: run enable, active slots, status clear
//   slot_tick, frame_sync        serializer slot boundary and slot-0 marker
//   ch_tx_data/valid/ready       per-channel TX words into the holding registers
//   pcm_tx_data/valid            word for the slot being served
//   pcm_rx_data/slot/valid       word received from the serializer
//   ch_rx_data/valid             routed RX word, one-hot channel pulse
//   cur_slot, running            slot being served, RUN indicator
//   underrun, sync_err           sticky status
module tdm_slot_scheduler
  import tdm_pkg::*;
#(
  parameter int unsigned CHANNEL_NUM = TDM_DEF_CHANNEL_NUM,
  parameter int unsigned SLOT_WIDTH  = TDM_DEF_SLOT_WIDTH,
  parameter int unsigned SLOT_IDX_W  = $clog2(CHANNEL_NUM)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              enable,
  input  logic [CHANNEL_NUM-1:0]            slot_mask,
  input  logic                              clr_status,
  input  logic                              slot_tick,
  input  logic                              frame_sync,
  input  logic [CHANNEL_NUM*SLOT_WIDTH-1:0] ch_tx_data,
  input  logic [CHANNEL_NUM-1:0]            ch_tx_valid,
  output logic [CHANNEL_NUM-1:0]            ch_tx_ready,
  output logic [SLOT_WIDTH-1:0]             pcm_tx_data,
  output logic                              pcm_tx_valid,
  input  logic [SLOT_WIDTH-1:0]             pcm_rx_data,
  input  logic [SLOT_IDX_W-1:0]             pcm_rx_slot,
  input  logic                              pcm_rx_valid,
  output logic [SLOT_WIDTH-1:0]             ch_rx_data,
  output logic [CHANNEL_NUM-1:0]            ch_rx_valid,
  output logic [SLOT_IDX_W-1:0]             cur_slot,
  output logic                              running,
  output logic [CHANNEL_NUM-1:0]            underrun,
  output logic                              sync_err
);

  localparam logic [SLOT_IDX_W-1:0] LAST_SLOT = SLOT_IDX_W'(CHANNEL_NUM - 1);

  tdm_state_e state_q, state_d;

  logic [SLOT_IDX_W-1:0]  cur_slot_q, cur_slot_d;
  logic [SLOT_IDX_W-1:0]  slot_inc;
  logic                   serve_vld;
  logic [SLOT_IDX_W-1:0]  serve_slot;
  logic                   serve_hit;
  logic                   sync_err_set;

  logic [CHANNEL_NUM-1:0] hold_vld;
  logic [SLOT_WIDTH-1:0]  hold_dat [CHANNEL_NUM];
  logic [CHANNEL_NUM-1:0] hold_pop;
  logic                   hold_flush;
  logic                   hold_accept_en;

  logic [SLOT_WIDTH-1:0]  pcm_tx_data_q, pcm_tx_data_d;
  logic                   pcm_tx_valid_q, pcm_tx_valid_d;
  logic [SLOT_WIDTH-1:0]  ch_rx_data_q, ch_rx_data_d;
  logic [CHANNEL_NUM-1:0] ch_rx_valid_q, ch_rx_valid_d;
  logic [CHANNEL_NUM-1:0] underrun_q, underrun_d, underrun_set;
  logic                   sync_err_q, sync_err_d;

  logic [CHANNEL_NUM-1:0] rx_onehot;
  logic                   rx_hit;

  assign slot_inc = SLOT_IDX_W'(tdm_next_slot(32'(cur_slot_q), CHANNEL_NUM));

  // ---------------------------------------------------------------------------
  // Control FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Control FSM: next state plus the per-tick serve decision. A frame_sync
  // tick in SYNC is itself served as slot 0. In RUN a frame_sync always
  // realigns to slot 0; a mismatch between frame_sync and the wrap point
  // flags a sync error without leaving RUN.
  always_comb begin
    state_d      = state_q;
    serve_vld    = 1'b0;
    serve_slot   = '0;
    sync_err_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (slot_tick && frame_sync) begin
          state_d    = ST_RUN;
          serve_vld  = 1'b1;
          serve_slot = '0;
        end
      end
      ST_RUN: begin
        if (slot_tick) begin
          serve_vld    = 1'b1;
          serve_slot   = frame_sync ? '0 : slot_inc;
          sync_err_set = frame_sync ^ (cur_slot_q == LAST_SLOT);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // Disable overrides everything: back to IDLE, nothing served or flagged.
    if (!enable) begin
      state_d      = ST_IDLE;
      serve_vld    = 1'b0;
      serve_slot   = '0;
      sync_err_set = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel TX holding registers
  // ---------------------------------------------------------------------------
  assign serve_hit      = serve_vld & slot_mask[serve_slot];
  assign hold_flush     = ~enable;
  assign hold_accept_en = (state_q != ST_IDLE);

  for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_hold
    // Popping an empty hold is harmless; a same-cycle load still lands.
    assign hold_pop[c] = serve_hit && (serve_slot == SLOT_IDX_W'(c));

    tdm_tx_hold #(
      .WIDTH (SLOT_WIDTH)
    ) u_hold (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush_i     (hold_flush),
      .accept_en_i (hold_accept_en),
      .in_vld_i    (ch_tx_valid[c]),
      .in_dat_i    (ch_tx_data[c*SLOT_WIDTH +: SLOT_WIDTH]),
      .in_rdy_o    (ch_tx_ready[c]),
      .pop_i       (hold_pop[c]),
      .out_vld_o   (hold_vld[c]),
      .out_dat_o   (hold_dat[c])
    );
  end

  // ---------------------------------------------------------------------------
  // RX routing: shifting past the top channel yields zero, so slot indices
  // beyond CHANNEL_NUM-1 never match the mask and the word is dropped.
  // ---------------------------------------------------------------------------
  assign rx_onehot = CHANNEL_NUM'(1) << pcm_rx_slot;
  assign rx_hit    = enable && (state_q == ST_RUN) && pcm_rx_valid &&
                     (|(rx_onehot & slot_mask));

  // ---------------------------------------------------------------------------
  // Datapath / status next state
  // ---------------------------------------------------------------------------
  always_comb begin
    cur_slot_d     = cur_slot_q;
    pcm_tx_data_d  = pcm_tx_data_q;
    pcm_tx_valid_d = 1'b0;
    ch_rx_data_d   = ch_rx_data_q;
    ch_rx_valid_d  = '0;
    underrun_set   = '0;

    if (!enable) begin
      cur_slot_d = '0;
    end else if (serve_vld) begin
      cur_slot_d = serve_slot;
    end

    if (serve_hit) begin
      pcm_tx_valid_d = 1'b1;
      if (hold_vld[serve_slot]) begin
        pcm_tx_data_d = hold_dat[serve_slot];
      end else begin
        pcm_tx_data_d            = '0;
        underrun_set[serve_slot] = 1'b1;
      end
    end

    if (rx_hit) begin
      ch_rx_data_d  = pcm_rx_data;
      ch_rx_valid_d = rx_onehot;
    end

    // Set wins over a same-cycle clear.
    underrun_d = (underrun_q & ~{CHANNEL_NUM{clr_status}}) | underrun_set;
    sync_err_d = (sync_err_q & ~clr_status) | sync_err_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_slot_q     <= '0;
      pcm_tx_data_q  <= '0;
      pcm_tx_valid_q <= 1'b0;
      ch_rx_data_q   <= '0;
      ch_rx_valid_q  <= '0;
      underrun_q     <= '0;
      sync_err_q     <= 1'b0;
    end else begin
      cur_slot_q     <= cur_slot_d;
      pcm_tx_data_q  <= pcm_tx_data_d;
      pcm_tx_valid_q <= pcm_tx_valid_d;
      ch_rx_data_q   <= ch_rx_data_d;
      ch_rx_valid_q  <= ch_rx_valid_d;
      underrun_q     <= underrun_d;
      sync_err_q     <= sync_err_d;
    end
  end

  assign cur_slot     = cur_slot_q;
  assign running      = (state_q == ST_RUN);
  assign pcm_tx_data  = pcm_tx_data_q;
  assign pcm_tx_valid = pcm_tx_valid_q;
  assign ch_rx_data   = ch_rx_data_q;
  assign ch_rx_valid  = ch_rx_valid_q;
  assign underrun     = underrun_q;
  assign sync_err     = sync_err_q;

endmodule

// File: tb/tb_tdm_slot_scheduler.sv
// Purpose: self-checking bench for tdm_slot_scheduler (directed scenarios + random).
// Latency: expects 1-cycle TX serve and RX routing.
// Backpressure: drives ch_tx_valid without waiting; the model honours ready.
module tb_tdm_slot_scheduler;

  localparam int N  = 8;
  localparam int W  = 16;
  localparam int IW = 3;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [N-1:0]     slot_mask;
  logic             clr_status;
  logic             slot_tick;
  logic             frame_sync;
  logic [N*W-1:0]   ch_tx_data;
  logic [N-1:0]     ch_tx_valid;
  logic [N-1:0]     ch_tx_ready;
  logic [W-1:0]     pcm_tx_data;
  logic             pcm_tx_valid;
  logic [W-1:0]     pcm_rx_data;
  logic [IW-1:0]    pcm_rx_slot;
  logic             pcm_rx_valid;
  logic [W-1:0]     ch_rx_data;
  logic [N-1:0]     ch_rx_valid;
  logic [IW-1:0]    cur_slot;
  logic             running;
  logic [N-1:0]     underrun;
  logic             sync_err;

  always #5 clk = ~clk;

  tdm_slot_scheduler #(
    .CHANNEL_NUM (N),
    .SLOT_WIDTH  (W),
    .SLOT_IDX_W  (IW)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .enable       (enable),
    .slot_mask    (slot_mask),
    .clr_status   (clr_status),
    .slot_tick    (slot_tick),
    .frame_sync   (frame_sync),
    .ch_tx_data   (ch_tx_data),
    .ch_tx_valid  (ch_tx_valid),
    .ch_tx_ready  (ch_tx_ready),
    .pcm_tx_data  (pcm_tx_data),
    .pcm_tx_valid (pcm_tx_valid),
    .pcm_rx_data  (pcm_rx_data),
    .pcm_rx_slot  (pcm_rx_slot),
    .pcm_rx_valid (pcm_rx_valid),
    .ch_rx_data   (ch_rx_data),
    .ch_rx_valid  (ch_rx_valid),
    .cur_slot     (cur_slot),
    .running      (running),
    .underrun     (underrun),
    .sync_err     (sync_err)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference model: 0 = idle, 1 = waiting for frame sync, 2 = running.
  int           m_mode;
  int           m_cur;
  bit           m_hv [N];
  logic [W-1:0] m_hd [N];
  logic [N-1:0] m_ur;
  bit           m_se;
  bit           e_txv;
  logic [W-1:0] e_txd;
  logic [N-1:0] e_rxv;
  logic [W-1:0] e_rxd;

  task automatic model_step();
    int           pm;
    int           served;
    bit           rdy [N];
    logic [N-1:0] ur_set;
    bit           se_set;
    pm     = m_mode;
    served = -1;
    ur_set = '0;
    se_set = 0;
    e_txv  = 0;
    e_rxv  = '0;
    for (int c = 0; c < N; c++) rdy[c] = (pm != 0) && !m_hv[c];
    if (!enable) begin
      for (int c = 0; c < N; c++) m_hv[c] = 0;
      m_cur  = 0;
      m_mode = 0;
    end else begin
      if (pm == 0) m_mode = 1;
      else if (pm == 1 && slot_tick && frame_sync) begin
        served = 0;
        m_mode = 2;
      end else if (pm == 2 && slot_tick) begin
        served = frame_sync ? 0 : (m_cur + 1) % N;
        se_set = (frame_sync != (m_cur == N - 1));
      end
      if (served >= 0) begin
        m_cur = served;
        if (slot_mask[served]) begin
          e_txv = 1;
          if (m_hv[served]) begin
            e_txd        = m_hd[served];
            m_hv[served] = 0;
          end else begin
            e_txd          = '0;
            ur_set[served] = 1'b1;
          end
        end
      end
      for (int c = 0; c < N; c++) begin
        if (ch_tx_valid[c] && rdy[c]) begin
          m_hv[c] = 1;
          m_hd[c] = ch_tx_data[c*W +: W];
        end
      end
      if (pm == 2 && pcm_rx_valid && int'(pcm_rx_slot) < N && slot_mask[pcm_rx_slot]) begin
        e_rxv[pcm_rx_slot] = 1'b1;
        e_rxd              = pcm_rx_data;
      end
    end
    m_ur = (m_ur & ~{N{clr_status}}) | ur_set;
    m_se = (m_se && !clr_status) || se_set;
  endtask

  // Advance one clock with the current inputs, then compare every output.
  task automatic step();
    logic [N-1:0] e_rdy;
    model_step();
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) e_rdy[c] = (m_mode != 0) && !m_hv[c];
    check_val("running",      running,      (m_mode == 2));
    check_val("cur_slot",     cur_slot,     m_cur);
    check_val("ch_tx_ready",  ch_tx_ready,  e_rdy);
    check_val("pcm_tx_valid", pcm_tx_valid, e_txv);
    check_val("pcm_tx_data",  pcm_tx_data,  e_txd);
    check_val("ch_rx_valid",  ch_rx_valid,  e_rxv);
    check_val("ch_rx_data",   ch_rx_data,   e_rxd);
    check_val("underrun",     underrun,     m_ur);
    check_val("sync_err",     sync_err,     m_se);
    slot_tick    = 1'b0;
    frame_sync   = 1'b0;
    clr_status   = 1'b0;
    ch_tx_valid  = '0;
    pcm_rx_valid = 1'b0;
  endtask

  task automatic tick(input bit fs);
    slot_tick  = 1'b1;
    frame_sync = fs;
    step();
  endtask

  task automatic tick_gap(input bit fs);
    tick(fs);
    step();
  endtask

  task automatic load(input logic [N-1:0] vmask, input logic [W-1:0] base);
    for (int c = 0; c < N; c++) ch_tx_data[c*W +: W] = base + W'(c);
    ch_tx_valid = vmask;
    step();
  endtask

  initial begin
    rst_n        = 1'b0;
    enable       = 1'b0;
    slot_mask    = '0;
    clr_status   = 1'b0;
    slot_tick    = 1'b0;
    frame_sync   = 1'b0;
    ch_tx_data   = '0;
    ch_tx_valid  = '0;
    pcm_rx_data  = '0;
    pcm_rx_slot  = '0;
    pcm_rx_valid = 1'b0;
    m_mode = 0; m_cur = 0; m_ur = '0; m_se = 0;
    e_txv = 0; e_txd = '0; e_rxv = '0; e_rxd = '0;
    for (int c = 0; c < N; c++) begin m_hv[c] = 0; m_hd[c] = '0; end

    #12;
    check_val("rst_running",  running,      0);
    check_val("rst_txv",      pcm_tx_valid, 0);
    check_val("rst_ready",    ch_tx_ready,  0);
    check_val("rst_cur_slot", cur_slot,     0);
    check_val("rst_underrun", underrun,     0);
    check_val("rst_sync_err", sync_err,     0);
    check_val("rst_rxv",      ch_rx_valid,  0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Bring-up: ticks without frame_sync are ignored until the first sync.
    enable    = 1'b1;
    slot_mask = '1;
    step();
    for (int k = 0; k < 3; k++) begin
      tick(0);
      check_val("bringup_txv", pcm_tx_valid, 0);
      check_val("bringup_run", running, 0);
      step();
    end
    tick(1);
    check_val("bringup_enter_run", running, 1);
    check_val("bringup_enter_slot", cur_slot, 0);
    step();
    for (int k = 0; k < 7; k++) tick_gap(0);
    clr_status = 1'b1;
    step();
    check_val("clr_underrun", underrun, 0);

    // TX order: all channels preloaded, one full frame.
    load('1, 16'h1000);
    for (int k = 0; k < N; k++) begin
      tick(k == 0);
      check_val("order_txv", pcm_tx_valid, 1);
      check_val("order_data", pcm_tx_data, 16'h1000 + k);
      step();
      check_val("order_gap_txv", pcm_tx_valid, 0);
    end
    check_val("order_no_underrun", underrun, 0);

    // Underrun and mask: only slots 0 and 2 active, only ch0 loaded.
    slot_mask = 8'h05;
    load(8'h01, 16'hBEEF);
    for (int k = 0; k < N; k++) begin
      tick(k == 0);
      if (k == 0) begin
        check_val("mask_s0_txv", pcm_tx_valid, 1);
        check_val("mask_s0_data", pcm_tx_data, 16'hBEEF);
      end else if (k == 2) begin
        check_val("mask_s2_txv", pcm_tx_valid, 1);
        check_val("mask_s2_data", pcm_tx_data, 0);
        check_val("mask_s2_underrun", underrun, 8'h04);
      end else begin
        check_val("mask_off_txv", pcm_tx_valid, 0);
      end
      step();
    end

    // Sync errors: early frame_sync, missing frame_sync, set beats clear.
    slot_mask = '1;
    tick_gap(1);
    tick_gap(0);
    tick_gap(0);
    tick(1);
    check_val("sync_early_err", sync_err, 1);
    check_val("sync_early_slot", cur_slot, 0);
    check_val("sync_early_run", running, 1);
    step();
    clr_status = 1'b1;
    step();
    check_val("sync_clr", sync_err, 0);
    for (int k = 0; k < 7; k++) tick_gap(0);
    tick(0);
    check_val("sync_miss_slot", cur_slot, 0);
    check_val("sync_miss_err", sync_err, 1);
    step();
    clr_status = 1'b1;
    step();
    clr_status = 1'b1;
    tick(1);
    check_val("sync_set_wins", sync_err, 1);
    step();

    // RX routing.
    pcm_rx_valid = 1'b1;
    pcm_rx_slot  = 3'd5;
    pcm_rx_data  = 16'hA5A5;
    step();
    check_val("rx_onehot", ch_rx_valid, 8'h20);
    check_val("rx_data", ch_rx_data, 16'hA5A5);
    slot_mask    = 8'hDF;
    pcm_rx_valid = 1'b1;
    pcm_rx_slot  = 3'd5;
    pcm_rx_data  = 16'h1234;
    step();
    check_val("rx_masked", ch_rx_valid, 0);
    check_val("rx_data_hold", ch_rx_data, 16'hA5A5);
    slot_mask = '1;

    // Disable mid-frame with full holds, then re-enable.
    tick_gap(0);
    load('1, 16'h2000);
    enable = 1'b0;
    step();
    check_val("dis_running", running, 0);
    check_val("dis_ready", ch_tx_ready, 0);
    check_val("dis_underrun_kept", underrun, 8'h03);
    check_val("dis_slot", cur_slot, 0);
    enable = 1'b1;
    step();
    check_val("reen_ready", ch_tx_ready, 8'hFF);
    check_val("reen_running", running, 0);
    tick(0);
    check_val("reen_wait_txv", pcm_tx_valid, 0);
    check_val("reen_wait_run", running, 0);
    step();
    tick(1);
    check_val("reen_run", running, 1);
    check_val("reen_flushed_txv", pcm_tx_valid, 1);
    check_val("reen_flushed_data", pcm_tx_data, 0);
    step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      enable     = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 49) == 0) slot_mask = N'($urandom);
      clr_status = ($urandom_range(0, 29) == 0);
      slot_tick  = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 9) == 0) frame_sync = 1'($urandom);
      else if (m_mode == 1)          frame_sync = ($urandom_range(0, 3) == 0);
      else                           frame_sync = (m_cur == N - 1);
      ch_tx_valid = N'($urandom);
      for (int c = 0; c < N; c++) ch_tx_data[c*W +: W] = W'($urandom);
      pcm_rx_valid = ($urandom_range(0, 2) == 0);
      pcm_rx_slot  = IW'($urandom);
      pcm_rx_data  = W'($urandom);
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
